// File: rtl/ifm_buf_pkg.sv
// Shared types and constants for the IFM window buffer.
package ifm_buf_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    RSVD  = 2'b11
  } ifm_mode_e;

  localparam int LANE0_MSB = 23;
  localparam int LANE1_MSB = 15;
  localparam int LANE2_MSB = 7;

  typedef logic signed [7:0] act_t;

endpackage

// File: rtl/ifm_row_reg.sv
// One three-activation window row: load all lanes, slide left by one column, or hold.
module ifm_row_reg
  import ifm_buf_pkg::*;
#(
  parameter int INPUT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [INPUT_WIDTH-1:0] din,
  output act_t                   row [3]
);

  act_t row_q [3];
  act_t row_d [3];

  // Top byte of each read word carries no data.
  logic unused_hi;
  assign unused_hi = ^din[INPUT_WIDTH-1:LANE0_MSB+1];

  always_comb begin
    row_d = row_q;
    if (en) begin
      case (ifm_mode_e'(mode))
        LOAD: begin
          row_d[0] = din[LANE0_MSB -: 8];
          row_d[1] = din[LANE1_MSB -: 8];
          row_d[2] = din[LANE2_MSB -: 8];
        end
        SHIFT: begin
          row_d[0] = row_q[1];
          row_d[1] = row_q[2];
          row_d[2] = din[LANE2_MSB -: 8];
        end
        default: ;
      endcase
    end
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int j = 0; j < 3; j++) row_q[j] <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  assign row = row_q;

endmodule

// File: rtl/ifm_buf.sv
// Input-feature-map window buffer for the 3x3 PE array.
// Optional IFM_BUF_VALID_EN adds a registered ifm_valid pulse after each window change.
module ifm_buf
  import ifm_buf_pkg::*;
#(
  parameter int INPUT_WIDTH   = 32,
  parameter int OUTPUT_WIDTH  = 8,
  parameter int INPUT_IFM_REG = 3,
  parameter int PE_ARR_SIZE   = 9
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [INPUT_IFM_REG-1:0]       ifm_read,
  input  logic [1:0]                     mode,
  input  logic [INPUT_WIDTH-1:0]         ifm_input  [INPUT_IFM_REG],
`ifdef IFM_BUF_VALID_EN
  output logic                           ifm_valid,
`endif
  output logic signed [OUTPUT_WIDTH-1:0] ifm_output [PE_ARR_SIZE]
);

  for (genvar i = 0; i < INPUT_IFM_REG; i++) begin : g_row
    act_t row [3];

    ifm_row_reg #(
      .INPUT_WIDTH(INPUT_WIDTH)
    ) u_row (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (ifm_read[i]),
      .mode (mode),
      .din  (ifm_input[i]),
      .row  (row)
    );

    for (genvar j = 0; j < 3; j++) begin : g_col
      assign ifm_output[3*i+j] = row[j];
    end
  end

`ifdef IFM_BUF_VALID_EN
  logic valid_q;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= ((mode == LOAD) || (mode == SHIFT)) && (|ifm_read);
    end
  end

  assign ifm_valid = valid_q;
`endif

endmodule

// File: tb/tb_ifm_buf.sv
// Self-checking bench for ifm_buf: directed vector table, random run against a row-word model.
module tb_ifm_buf;

  logic                clk;
  logic                rst_n;
  logic [2:0]          rd;
  logic [1:0]          md;
  logic [31:0]         din  [3];
  logic signed [7:0]   dout [9];
`ifdef IFM_BUF_VALID_EN
  logic                vld;
  logic                exp_vld;
`endif

  int nchk;
  int nfail;

  // Reference: each row is a 24-bit word, column 0 in the top byte.
  logic [23:0] mdl [3];

  typedef struct {
    logic [1:0]  m;
    logic [2:0]  r;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [71:0] e;
  } vec_t;

  vec_t tbl [12];

  ifm_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ifm_read  (rd),
    .mode      (md),
    .ifm_input (din),
`ifdef IFM_BUF_VALID_EN
    .ifm_valid (vld),
`endif
    .ifm_output(dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] pack_out();
    logic [71:0] v;
    for (int k = 0; k < 9; k++) v[71-8*k -: 8] = dout[k];
    return v;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance the model by one edge using the currently driven inputs.
  task automatic mdl_step();
    for (int i = 0; i < 3; i++) begin
      if (rd[i]) begin
        if (md == 2'b01) mdl[i] = din[i][23:0];
        else if (md == 2'b10) mdl[i] = {mdl[i][15:0], din[i][7:0]};
      end
    end
`ifdef IFM_BUF_VALID_EN
    exp_vld = ((md == 2'b01) || (md == 2'b10)) && (rd != 3'b000);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name);
    chk(name, pack_out(), {mdl[0], mdl[1], mdl[2]});
`ifdef IFM_BUF_VALID_EN
    chk({name, "_valid"}, {71'd0, vld}, {71'd0, exp_vld});
`endif
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    for (int i = 0; i < 3; i++) mdl[i] = '0;
`ifdef IFM_BUF_VALID_EN
    exp_vld = 1'b0;
`endif

    tbl[0]  = '{2'b01, 3'b111, 32'h00010203, 32'h00040506, 32'h00070809, 72'h010203_040506_070809};
    tbl[1]  = '{2'b01, 3'b001, 32'h000A0B0C, 32'h000F0F0F, 32'h000F0F0F, 72'h0A0B0C_040506_070809};
    tbl[2]  = '{2'b01, 3'b010, 32'h000F0F0F, 32'h000D0E0F, 32'h000F0F0F, 72'h0A0B0C_0D0E0F_070809};
    tbl[3]  = '{2'b01, 3'b100, 32'h000F0F0F, 32'h000F0F0F, 32'h000A0A0A, 72'h0A0B0C_0D0E0F_0A0A0A};
    tbl[4]  = '{2'b10, 3'b001, 32'h00000011, 32'h000F0F0F, 32'h000F0F0F, 72'h0B0C11_0D0E0F_0A0A0A};
    tbl[5]  = '{2'b00, 3'b111, 32'h12345678, 32'h9ABCDEF0, 32'h13579BDF, 72'h0B0C11_0D0E0F_0A0A0A};
    tbl[6]  = '{2'b11, 3'b111, 32'h87654321, 32'h0FEDCBA9, 32'hFDB97531, 72'h0B0C11_0D0E0F_0A0A0A};
    tbl[7]  = '{2'b00, 3'b111, 32'h11111111, 32'h22222222, 32'h33333333, 72'h0B0C11_0D0E0F_0A0A0A};
    tbl[8]  = '{2'b01, 3'b111, 32'hFF112233, 32'hFF445566, 32'hFF778899, 72'h112233_445566_778899};
    tbl[9]  = '{2'b10, 3'b111, 32'h123456AA, 32'hFFFFFFBB, 32'h000000CC, 72'h2233AA_5566BB_8899CC};
    tbl[10] = '{2'b10, 3'b000, 'x,           'x,           'x,           72'h2233AA_5566BB_8899CC};
    tbl[11] = '{2'b01, 3'b000, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0BADF00D, 72'h2233AA_5566BB_8899CC};

    // Reset held across two edges with random LOAD-like inputs.
    rst_n = 1'b1;
    md    = 2'($urandom_range(0, 3));
    rd    = 3'($urandom);
    for (int i = 0; i < 3; i++) din[i] = $urandom;
    #14;
    chk("reset_outputs", pack_out(), 72'd0);
`ifdef IFM_BUF_VALID_EN
    chk("reset_valid", {71'd0, vld}, 72'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b0;

    for (int t = 0; t < 12; t++) begin
      md     = tbl[t].m;
      rd     = tbl[t].r;
      din[0] = tbl[t].i0;
      din[1] = tbl[t].i1;
      din[2] = tbl[t].i2;
      mdl_step();
      step();
      chk($sformatf("vec%0d", t), pack_out(), tbl[t].e);
`ifdef IFM_BUF_VALID_EN
      chk($sformatf("vec%0d_valid", t), {71'd0, vld}, {71'd0, exp_vld});
`endif
    end

    for (int n = 0; n < 200; n++) begin
      md = 2'($urandom_range(0, 3));
      rd = 3'($urandom);
      for (int i = 0; i < 3; i++) din[i] = $urandom;
      mdl_step();
      step();
      chk_state($sformatf("rand%0d", n));
    end

    // Asynchronous reset mid-cycle, well clear of any clock edge.
    md = 2'b01;
    rd = 3'b111;
    din[0] = 32'h00A1A2A3;
    din[1] = 32'h00B1B2B3;
    din[2] = 32'h00C1C2C3;
    mdl_step();
    step();
    chk_state("preload");
    #2;
    rst_n = 1'b1;
    #1;
    chk("async_reset", pack_out(), 72'd0);
`ifdef IFM_BUF_VALID_EN
    chk("async_reset_valid", {71'd0, vld}, 72'd0);
`endif
    step();
    chk("reset_blocks_load", pack_out(), 72'd0);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) mdl[i] = '0;
    md = 2'b10;
    rd = 3'b101;
    din[0] = 32'h0000007F;
    din[1] = 32'h00000055;
    din[2] = 32'h00000080;
    mdl_step();
    step();
    chk_state("post_reset_shift");
    md = 2'b00;
    mdl_step();
    step();
    chk_state("post_reset_hold");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
